// File: rtl/muldiv_if.sv
// Handshake and data bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_if #(
  parameter int XLEN = 64
);
  logic            start_valid;
  logic            start_ready;
  logic [2:0]      muldiv_funct;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            result_ready;
  logic            busy;

  modport master (
    output start_valid, muldiv_funct, operand_a, operand_b, result_ready,
    input  start_ready, result, result_valid, busy
  );

  modport slave (
    input  start_valid, muldiv_funct, operand_a, operand_b, result_ready,
    output start_ready, result, result_valid, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide: one bit per cycle over XLEN cycles, with
// divide-by-zero and signed overflow resolved straight from IDLE.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic    clock,
  input  logic    reset_n,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct_q, funct_d;
  logic              neg_q, neg_d;         // negate product / quotient
  logic              a_neg_q, a_neg_d;     // remainder follows the dividend sign
  logic [2*XLEN-1:0] acc_q, acc_d;         // mul: {partial product, multiplier}; div: {0, dividend/quotient}
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   opb_q, opb_d;         // mul: |multiplicand|; div: |divisor|
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode for the accept cycle.
  logic [2:0]      f;
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    f        = bus.muldiv_funct;
    a_signed = (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    b_signed = a_signed && (f != 3'b010);
    a_neg    = a_signed && bus.operand_a[XLEN-1];
    b_neg    = b_signed && bus.operand_b[XLEN-1];
    mag_a    = a_neg ? -bus.operand_a : bus.operand_a;
    mag_b    = b_neg ? -bus.operand_b : bus.operand_b;
    div_zero = f[2] && (bus.operand_b == '0);
    div_ovf  = f[2] && !f[0] && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.operand_b == '1);
    if (f[1]) special_res = div_zero ? bus.operand_a : '0;
    else      special_res = div_zero ? '1 : bus.operand_a;
  end

  // One iteration of shift-add multiply and restoring divide.
  logic [XLEN:0]     mul_sum, div_shift;
  logic [2*XLEN-1:0] mul_nx, prod_fix;
  logic [XLEN-1:0]   div_sub, rem_nx, quo_nx, quo_fix, rem_fix, final_res;
  logic              div_ok;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    mul_nx    = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_ok    = (div_shift >= {1'b0, opb_q});
    // The difference is below the divisor whenever it is kept, so XLEN bits suffice.
    div_sub   = div_shift[XLEN-1:0] - opb_q;
    rem_nx    = div_ok ? div_sub : div_shift[XLEN-1:0];
    quo_nx    = {acc_q[XLEN-2:0], div_ok};
    prod_fix  = neg_q ? -mul_nx : mul_nx;
    quo_fix   = neg_q ? -quo_nx : quo_nx;
    rem_fix   = a_neg_q ? -rem_nx : rem_nx;
    case (funct_q)
      3'b000:                 final_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // NOTE: every next-state signal takes its held value first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    funct_d  = funct_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          funct_d = f;
          neg_d   = a_neg ^ b_neg;
          a_neg_d = a_neg;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
          end else begin
            acc_d   = {{XLEN{1'b0}}, f[2] ? mag_a : mag_b};
            opb_d   = f[2] ? mag_b : mag_a;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (funct_q[2]) begin
          acc_d = {acc_q[2*XLEN-1:XLEN], quo_nx};
          rem_d = rem_nx;
        end else begin
          acc_d = mul_nx;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.result       = result_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit implementing the RISC-V M-extension operations for a parametrised data width (XLEN = 64 for RV64I). It sits beside the combinational `alu` in the execute stage. It accepts one operation through a valid/ready handshake, computes it one bit per cycle over XLEN cycles, and holds the result until the consumer takes it. Divide-by-zero and signed overflow are resolved in one cycle without iterating.

## Interface
- `XLEN`, default 64, operand/result width; any even value ≥ 8.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  operation request.
- `start_ready`  out  1  unit can accept; high only in IDLE.
- `muldiv_funct`  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operand_a`  in  XLEN  rs1 (multiplicand/dividend).
- `operand_b`  in  XLEN  rs2 (multiplier/divisor).
- `result`  out  XLEN  registered result; valid while `result_valid`.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer takes result.
- `busy`  out  1  high in CALC or DONE.

## Operation
- Clock is `clock`; reset is `reset_n`, asynchronous and active-low. Asserting `reset_n` low forces: state IDLE, `result` = 0, `result_valid` = 0, counter = 0, all internal operand registers = 0. `start_ready` = 1 and `busy` = 0 during and after reset.
- State machine:
  - IDLE: on `start_valid & start_ready`, latch funct and operands.
    - If a special case applies, load `result` and go to DONE.
    - Otherwise load magnitudes, clear the counter and go to CALC.
  - CALC: one iteration per cycle. When the counter reaches XLEN−1, apply the sign fix-up, load `result` and go to DONE.
  - DONE: `result_valid` = 1. On `result_ready`, go to IDLE. No new operation is accepted in the same cycle.
- Signedness:
  - MUL/MULH/DIV/REM treat both operands as signed.
  - MULHSU treats a as signed and b as unsigned.
  - MULHU/DIVU/REMU treat both operands as unsigned.
  - Signed operands are converted to magnitude before iterating.
- Multiply: shift-add on a 2·XLEN accumulator. The product is negated if the operand signs differ and the operation is signed. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, with an XLEN+1-bit partial remainder.
  - The quotient is negated if the signs differ (DIV).
  - The remainder takes the dividend's sign (REM).
- Special cases (division only, detected in IDLE):
  - b = 0: quotient = all ones; remainder = a.
  - Signed, a = 1 followed by XLEN−1 zeros, b = all ones: quotient = a; remainder = 0.
- Counter width is clog2(XLEN)+1. It must not wrap inside CALC.
- Operand inputs are ignored outside the accept cycle.

## Timing
- Accept on edge T0.
- Normal operations: CALC spans T0+1 … T0+XLEN. `result_valid` rises after edge T0+XLEN+1, giving a latency of XLEN+1 cycles.
- Special cases: `result_valid` rises after edge T0+1, giving a latency of 1.
- `result` and `result_valid` hold stable in DONE for any length of `result_ready` backpressure.
- Handshake completes at the DONE edge with `result_ready` = 1. `result_valid` falls after that edge, and `start_ready` rises the same cycle.
- Minimum issue interval: XLEN+2 cycles for normal operations, 2 cycles for special cases.
- `start_valid` while not ready has no effect. The requester must hold it.
- Reset mid-CALC or mid-DONE aborts the operation immediately and asynchronously. The result is discarded, and `start_ready` is 1 in the cycle after release.

## Test plan
- MUL a=7, b=−3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB; `result_valid` exactly 65 cycles after accept.
- MULH a=b=0x8000_0000_0000_0000 -> 0x4000_0000_0000_0000. MULHU a=b=all ones -> 0xFFFF_FFFF_FFFF_FFFE. MULHSU a=−1, b=2 -> all ones.
- DIV a=−7, b=2 -> −3 (…FFFD). REM a=−7, b=2 -> −1 (all ones). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> all ones; REMU 5/0 -> 5; DIV min/−1 -> 0x8000_0000_0000_0000; REM min/−1 -> 0. Each with `result_valid` one cycle after accept.
- Backpressure: hold `result_ready` = 0 for 10 cycles in DONE -> `result` stable, `start_ready` = 0, `busy` = 1, and a second `start_valid` is ignored. Release -> IDLE the next cycle, and the second request is then accepted.
- Pull `reset_n` low at CALC cycle 20 -> outputs go to 0 asynchronously and `start_ready` = 1. A new MUL 3×4 then returns 12 with full latency.
